// File: rtl/reg_bank.sv
//-----------------------------------------------------------------------------
// reg_bank
//
// Purpose:
//   Register storage sitting behind the register interconnect. It holds
//   REG_DEPTH x DATA_WIDTH registers in an inferred multi-port RAM and serves
//   the interconnect as one read slave and one write slave.
//
//   The address space is split in two regions:
//     - addr <  RO_BASE : configuration, written by the bus, read by both the
//                         bus and the hardware read port.
//     - addr >= RO_BASE : status, written only by the hardware write port,
//                         read-only from the bus (bus writes are acknowledged
//                         but dropped).
//
//   All RAM reads are read-first: a read and a write to the same address at
//   the same edge return the value held before that edge.
//   Storage is never cleared by rstn; only control state and outputs are.
//
// Ports:
//   clk                 clock, all logic on the rising edge
//   rstn                synchronous active-low reset
//   i_r_bus_addr        bus read address (sampled when a read is accepted)
//   i_r_bus_valid       bus read request
//   o_r_bus_data        bus read data, non-zero only while o_r_bus_ready is high
//   o_r_bus_ready       one-cycle read response strobe, 2 cycles after valid
//   i_w_bus_addr        bus write address (sampled when a write is accepted)
//   i_w_bus_data        bus write data (sampled with the address)
//   i_w_bus_valid       bus write request
//   o_w_bus_ready       one-cycle write acknowledge, 1 cycle after valid
//   i_hw_wr_en          hardware status write strobe
//   i_hw_wr_addr        hardware status write address (config region ignored)
//   i_hw_wr_data        hardware status write data
//   i_hw_rd_addr        hardware read address
//   o_hw_rd_data        contents of i_hw_rd_addr one cycle later
//   o_wr_notify         one-cycle pulse after a bus write commits to config
//   o_wr_notify_addr    address of the last committed config write (held)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_bank #(
    parameter  int REG_DEPTH    = 256,
    parameter  int DATA_WIDTH   = 32,
    parameter  int RO_BASE      = 128,
    localparam int LB_REG_DEPTH = $clog2(REG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic [LB_REG_DEPTH-1:0] i_r_bus_addr,
    input  logic                    i_r_bus_valid,
    output logic [DATA_WIDTH-1:0]   o_r_bus_data,
    output logic                    o_r_bus_ready,

    input  logic [LB_REG_DEPTH-1:0] i_w_bus_addr,
    input  logic [DATA_WIDTH-1:0]   i_w_bus_data,
    input  logic                    i_w_bus_valid,
    output logic                    o_w_bus_ready,

    input  logic                    i_hw_wr_en,
    input  logic [LB_REG_DEPTH-1:0] i_hw_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_hw_wr_data,
    input  logic [LB_REG_DEPTH-1:0] i_hw_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_hw_rd_data,

    output logic                    o_wr_notify,
    output logic [LB_REG_DEPTH-1:0] o_wr_notify_addr
);

    // RO_BASE may equal REG_DEPTH (no status region), which does not fit in
    // an address, so region compares are done one bit wider.
    localparam logic [LB_REG_DEPTH:0] RO_BASE_EXT = (LB_REG_DEPTH+1)'(RO_BASE);

    // Read FSM encoding
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACC  = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    // Write FSM encoding
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_ACK  = 1'b1;

    //-------------------------------------------------------------------------
    // Storage and state
    //-------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   r_mem [REG_DEPTH];

    logic [1:0]              r_rdState;
    logic [LB_REG_DEPTH-1:0] r_rdAddr;
    logic [DATA_WIDTH-1:0]   r_rdMemQ;

    logic [0:0]              r_wrState;
    logic [LB_REG_DEPTH-1:0] r_wrAddr;
    logic [DATA_WIDTH-1:0]   r_wrData;
    logic                    r_wrNotify;
    logic [LB_REG_DEPTH-1:0] r_wrNotifyAddr;

    logic [DATA_WIDTH-1:0]   r_hwRdData;

    logic                    w_wrAddrInCfg;
    logic                    w_hwAddrInCfg;
    logic                    w_busCommit;
    logic                    w_hwCommit;

    //-------------------------------------------------------------------------
    // Region decode and write enables
    //-------------------------------------------------------------------------
    assign w_wrAddrInCfg = ({1'b0, r_wrAddr}     < RO_BASE_EXT);
    assign w_hwAddrInCfg = ({1'b0, i_hw_wr_addr} < RO_BASE_EXT);

    // A bus write commits on the edge that leaves W_ACK. Gating with rstn
    // discards a write whose acknowledge edge coincides with reset.
    assign w_busCommit = rstn && (r_wrState == W_ACK) && w_wrAddrInCfg;

    // Hardware may only update the status region.
    assign w_hwCommit  = i_hw_wr_en && !w_hwAddrInCfg;

    //-------------------------------------------------------------------------
    // RAM write ports. The two writers own disjoint regions, so both may fire
    // in the same cycle without any ordering concern.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busCommit) begin
            r_mem[r_wrAddr] <= r_wrData;
        end
        if (w_hwCommit) begin
            r_mem[i_hw_wr_addr] <= i_hw_wr_data;
        end
    end

    //-------------------------------------------------------------------------
    // Bus read RAM port. Loaded on the R_ACC edge from the latched address;
    // being non-blocking, it sees the pre-edge contents (read-first).
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_rdState == R_ACC) begin
            r_rdMemQ <= r_mem[r_rdAddr];
        end
    end

    //-------------------------------------------------------------------------
    // Hardware read RAM port, registered with a reset-to-zero output.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hwRdData <= '0;
        end else begin
            r_hwRdData <= r_mem[i_hw_rd_addr];
        end
    end

    //-------------------------------------------------------------------------
    // Read FSM. valid is only looked at in R_IDLE, so a master that keeps
    // valid high across the response cannot trigger a second transaction
    // before the FSM has returned to idle.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdState <= R_IDLE;
            r_rdAddr  <= '0;
        end else begin
            case (r_rdState)
                R_IDLE: begin
                    if (i_r_bus_valid) begin
                        r_rdAddr  <= i_r_bus_addr;
                        r_rdState <= R_ACC;
                    end
                end
                R_ACC: begin
                    r_rdState <= R_RESP;
                end
                R_RESP: begin
                    r_rdState <= R_IDLE;
                end
                default: begin
                    r_rdState <= R_IDLE;
                end
            endcase
        end
    end

    // Response data is forced to zero outside the response cycle so the
    // interconnect can OR slave data buses together.
    assign o_r_bus_ready = (r_rdState == R_RESP);
    assign o_r_bus_data  = (r_rdState == R_RESP) ? r_rdMemQ : '0;

    //-------------------------------------------------------------------------
    // Write FSM. Address and data are captured on acceptance; the commit and
    // the notify decision use only the captured copies.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wrState      <= W_IDLE;
            r_wrAddr       <= '0;
            r_wrData       <= '0;
            r_wrNotify     <= 1'b0;
            r_wrNotifyAddr <= '0;
        end else begin
            r_wrNotify <= 1'b0;
            case (r_wrState)
                W_IDLE: begin
                    if (i_w_bus_valid) begin
                        r_wrAddr  <= i_w_bus_addr;
                        r_wrData  <= i_w_bus_data;
                        r_wrState <= W_ACK;
                    end
                end
                W_ACK: begin
                    r_wrState <= W_IDLE;
                    if (w_wrAddrInCfg) begin
                        r_wrNotify     <= 1'b1;
                        r_wrNotifyAddr <= r_wrAddr;
                    end
                end
                default: begin
                    r_wrState <= W_IDLE;
                end
            endcase
        end
    end

    assign o_w_bus_ready    = (r_wrState == W_ACK);
    assign o_wr_notify      = r_wrNotify;
    assign o_wr_notify_addr = r_wrNotifyAddr;
    assign o_hw_rd_data     = r_hwRdData;

endmodule

// File: tb/tb_reg_bank.sv
//-----------------------------------------------------------------------------
// tb_reg_bank
//
// Self-checking bench for reg_bank. A reference copy of the register file is
// kept in the bench; bus reads push their expected data into a queue when the
// request is driven, and committed config writes push their expected notify
// address. A negedge monitor pops and compares whenever the DUT responds.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reg_bank;

    localparam int RO_BASE = 128;
    localparam int KIND_WR = 0;
    localparam int KIND_RD = 1;
    localparam int KIND_HW = 2;

    logic        clk;
    logic        rstn;
    logic [7:0]  rBusAddr;
    logic        rBusValid;
    logic [31:0] rBusData;
    logic        rBusReady;
    logic [7:0]  wBusAddr;
    logic [31:0] wBusData;
    logic        wBusValid;
    logic        wBusReady;
    logic        hwWrEn;
    logic [7:0]  hwWrAddr;
    logic [31:0] hwWrData;
    logic [7:0]  hwRdAddr;
    logic [31:0] hwRdData;
    logic        wrNotify;
    logic [7:0]  wrNotifyAddr;

    logic [31:0] model [256];
    logic [31:0] readExpQ [$];
    logic [7:0]  notifyExpQ [$];

    int checks;
    int failures;

    reg_bank #(
        .REG_DEPTH  (256),
        .DATA_WIDTH (32),
        .RO_BASE    (RO_BASE)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_r_bus_addr     (rBusAddr),
        .i_r_bus_valid    (rBusValid),
        .o_r_bus_data     (rBusData),
        .o_r_bus_ready    (rBusReady),
        .i_w_bus_addr     (wBusAddr),
        .i_w_bus_data     (wBusData),
        .i_w_bus_valid    (wBusValid),
        .o_w_bus_ready    (wBusReady),
        .i_hw_wr_en       (hwWrEn),
        .i_hw_wr_addr     (hwWrAddr),
        .i_hw_wr_data     (hwWrData),
        .i_hw_rd_addr     (hwRdAddr),
        .o_hw_rd_data     (hwRdData),
        .o_wr_notify      (wrNotify),
        .o_wr_notify_addr (wrNotifyAddr)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something deadlocks outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT responds
    always @(negedge clk) begin
        if (rBusReady) begin
            if (readExpQ.size() == 0) begin
                checkOutput("rdUnexpected", {31'b0, rBusReady}, 32'd0);
            end else begin
                checkOutput("rdData", rBusData, readExpQ.pop_front());
            end
        end else begin
            checkOutput("rdDataIdle", rBusData, 32'd0);
        end
        if (wrNotify) begin
            if (notifyExpQ.size() == 0) begin
                checkOutput("notifyUnexpected", {31'b0, wrNotify}, 32'd0);
            end else begin
                checkOutput("notifyAddr", {24'b0, wrNotifyAddr},
                            {24'b0, notifyExpQ.pop_front()});
            end
        end
    end

    task automatic startRead(input logic [7:0] addr);
        rBusAddr  = addr;
        rBusValid = 1'b1;
        readExpQ.push_back(model[addr]);
    endtask

    task automatic startWrite(input logic [7:0] addr, input logic [31:0] data);
        wBusAddr  = addr;
        wBusData  = data;
        wBusValid = 1'b1;
        if (int'(addr) < RO_BASE) begin
            model[addr] = data;
            notifyExpQ.push_back(addr);
        end
    endtask

    task automatic waitReadDone();
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rBusReady && lat < 8);
        rBusValid = 1'b0;
        checkOutput("rdLatency", 32'(lat), 32'd2);
        @(negedge clk);
        checkOutput("rdReadySingle", {31'b0, rBusReady}, 32'd0);
    endtask

    task automatic waitWriteDone();
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!wBusReady && lat < 8);
        wBusValid = 1'b0;
        checkOutput("wrLatency", 32'(lat), 32'd1);
        @(negedge clk);
        checkOutput("wrReadySingle", {31'b0, wBusReady}, 32'd0);
    endtask

    // One complete transaction of the given kind
    task automatic applyStimulus(input int kind, input logic [7:0] addr,
                                 input logic [31:0] data);
        @(posedge clk);
        #1;
        case (kind)
            KIND_WR: begin
                startWrite(addr, data);
                waitWriteDone();
            end
            KIND_RD: begin
                startRead(addr);
                waitReadDone();
            end
            default: begin
                hwWrEn   = 1'b1;
                hwWrAddr = addr;
                hwWrData = data;
                if (int'(addr) >= RO_BASE) begin
                    model[addr] = data;
                end
                @(posedge clk);
                #1;
                hwWrEn = 1'b0;
            end
        endcase
    endtask

    task automatic checkHwRead(input logic [7:0] addr);
        logic [31:0] exp;
        @(posedge clk);
        #1;
        hwRdAddr = addr;
        exp = model[addr];
        @(posedge clk);
        @(negedge clk);
        checkOutput("hwRdData", hwRdData, exp);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        rBusAddr  = '0;
        rBusValid = 1'b0;
        wBusAddr  = '0;
        wBusData  = '0;
        wBusValid = 1'b0;
        hwWrEn    = 1'b0;
        hwWrAddr  = '0;
        hwWrData  = '0;
        hwRdAddr  = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRdReady",   {31'b0, rBusReady}, 32'd0);
        checkOutput("rstRdData",    rBusData, 32'd0);
        checkOutput("rstWrReady",   {31'b0, wBusReady}, 32'd0);
        checkOutput("rstNotify",    {31'b0, wrNotify}, 32'd0);
        checkOutput("rstNotifyAdr", {24'b0, wrNotifyAddr}, 32'd0);
        checkOutput("rstHwRd",      hwRdData, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Seed status and config registers with known values
        applyStimulus(KIND_HW, 8'h80, 32'h55AA55AA);
        applyStimulus(KIND_HW, 8'hFF, 32'hCAFEF00D);
        applyStimulus(KIND_WR, 8'h05, 32'hDEADBEEF);
        applyStimulus(KIND_WR, 8'h00, 32'h00000011);
        applyStimulus(KIND_WR, 8'h10, 32'h10101010);
        applyStimulus(KIND_RD, 8'h05, 32'h0);
        checkHwRead(8'h05);

        // Bus write into the status region is acknowledged but dropped
        applyStimulus(KIND_WR, 8'h80, 32'h00001234);
        applyStimulus(KIND_RD, 8'h80, 32'h0);

        // hw writes only land in the status region
        applyStimulus(KIND_HW, 8'h90, 32'hA5A5A5A5);
        applyStimulus(KIND_HW, 8'h10, 32'h0000FFFF);
        applyStimulus(KIND_RD, 8'h90, 32'h0);
        applyStimulus(KIND_RD, 8'h10, 32'h0);
        checkHwRead(8'h90);

        // Read and write of the same address accepted together: old data
        @(posedge clk);
        #1;
        startRead(8'h05);
        startWrite(8'h05, 32'h00000001);
        fork
            waitReadDone();
            waitWriteDone();
        join
        applyStimulus(KIND_RD, 8'h05, 32'h0);

        // Back-to-back reads at both address extremes
        applyStimulus(KIND_RD, 8'h00, 32'h0);
        applyStimulus(KIND_RD, 8'hFF, 32'h0);
        checkHwRead(8'h05);

        // Reset while the read FSM is in R_ACC: no response follows
        @(posedge clk);
        #1;
        rBusAddr  = 8'h05;
        rBusValid = 1'b1;
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        rBusValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstMidRdReady", {31'b0, rBusReady}, 32'd0);
        checkOutput("rstMidHwRd",    hwRdData, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Reset at the W_ACK edge: the write is discarded, no notify
        @(posedge clk);
        #1;
        wBusAddr  = 8'h05;
        wBusData  = 32'hBAD0BAD0;
        wBusValid = 1'b1;
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        wBusValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstMidWrReady",  {31'b0, wBusReady}, 32'd0);
        checkOutput("rstMidWrNotify", {31'b0, wrNotify}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Both FSMs usable again and storage untouched by the aborted write
        applyStimulus(KIND_RD, 8'h05, 32'h0);
        applyStimulus(KIND_WR, 8'h7F, 32'h7F7F7F7F);
        applyStimulus(KIND_RD, 8'h7F, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("rdQueueDrained",     32'(readExpQ.size()), 32'd0);
        checkOutput("notifyQueueDrained", 32'(notifyExpQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
